// File: rtl/sayeh_seq_pkg.sv
// Shared encodings for the SAYEH address sequencer: FSM state codes and the
// op_kind values the instruction controller presents on the op handshake.
package sayeh_seq_pkg;

    localparam logic [2:0] ST_RST      = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_DISPATCH = 3'd2;
    localparam logic [2:0] ST_DRD      = 3'd3;
    localparam logic [2:0] ST_DWR      = 3'd4;
    localparam logic [2:0] ST_INCR     = 3'd5;
    localparam logic [2:0] ST_HALT     = 3'd6;

    localparam logic [2:0] OP_NEXT    = 3'd0;
    localparam logic [2:0] OP_BR_REL  = 3'd1;
    localparam logic [2:0] OP_JMP_REG = 3'd2;
    localparam logic [2:0] OP_LOAD    = 3'd3;
    localparam logic [2:0] OP_STORE   = 3'd4;
    localparam logic [2:0] OP_HALT    = 3'd5;

    // States in which the sequencer is waiting on memDataReady.
    function automatic logic is_mem_wait(input logic [2:0] st);
        return (st == ST_FETCH) || (st == ST_DRD) || (st == ST_DWR);
    endfunction

endpackage

// File: rtl/seq_timeout_ctr.sv
// Memory-wait watchdog: counts consecutive stalled cycles and flags the cycle
// in which the last allowed stall is reached. Used only with SEQ_TIMEOUT_EN.
module seq_timeout_ctr #(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic ExternalReset,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (ExternalReset || clr) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = run && (r_cnt == LAST);

endmodule

// File: rtl/address_sequencer.sv
// SAYEH address sequencer: fetch -> dispatch -> optional data access -> PC update.
// Optional memory-wait watchdog is enabled by defining SEQ_TIMEOUT_EN.
module address_sequencer
    import sayeh_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       ExternalReset,
    input  logic       memDataReady,
    input  logic       op_valid,
    input  logic [2:0] op_kind,
    output logic       op_ready,
    output logic       ResetPC,
    output logic       PCplusI,
    output logic       PCplus1,
    output logic       RplusI,
    output logic       Rplus0,
    output logic       EnablePC,
    output logic       ReadMem,
    output logic       WriteMem,
    output logic       IRload,
    output logic       halted,
    output logic       op_err,
    output logic       mem_timeout,
    output logic [2:0] dbg_state
);

    // Op handshake: an op transfers in any cycle where op_valid and op_ready are
    // both high; op_ready is high only in DISPATCH, and op_valid is ignored elsewhere.

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << CNT_W)) begin : g_bad_cfg
        $error("address_sequencer: TIMEOUT_CYC must be in 1 .. 2**CNT_W-1");
    end

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic       r_op_err;
    logic       w_accept;

    assign w_accept  = (r_state == ST_DISPATCH) && op_valid;
    assign dbg_state = r_state;
    assign op_err    = r_op_err;

`ifdef SEQ_TIMEOUT_EN
    logic w_wait;
    logic w_expired;
    logic r_mem_timeout;

    assign w_wait = is_mem_wait(r_state);

    seq_timeout_ctr #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk           (clk),
        .ExternalReset (ExternalReset),
        .run           (w_wait && !memDataReady),
        .clr           (w_next != r_state),
        .expired       (w_expired)
    );

    always_ff @(posedge clk) begin
        if (ExternalReset) begin
            r_mem_timeout <= 1'b0;
        end else begin
            r_mem_timeout <= w_expired;
        end
    end

    assign mem_timeout = r_mem_timeout;
`else
    assign mem_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (ExternalReset) begin
            r_state  <= ST_RST;
            r_op_err <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_op_err <= w_accept && (op_kind > OP_HALT);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RST:   w_next = ST_FETCH;
            ST_FETCH: if (memDataReady) w_next = ST_DISPATCH;
            ST_DISPATCH: begin
                if (op_valid) begin
                    case (op_kind)
                        OP_LOAD:  w_next = ST_DRD;
                        OP_STORE: w_next = ST_DWR;
                        OP_HALT:  w_next = ST_HALT;
                        default:  w_next = ST_FETCH;
                    endcase
                end
            end
            ST_DRD, ST_DWR: if (memDataReady) w_next = ST_INCR;
            ST_INCR: w_next = ST_FETCH;
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_RST;
        endcase
`ifdef SEQ_TIMEOUT_EN
        // A ready in the expiring cycle keeps w_expired low, so the access wins.
        if (w_expired) w_next = ST_HALT;
`endif
    end

    always_comb begin
        op_ready = 1'b0;
        ResetPC  = 1'b0;
        PCplusI  = 1'b0;
        PCplus1  = 1'b0;
        RplusI   = 1'b0;
        Rplus0   = 1'b0;
        EnablePC = 1'b0;
        ReadMem  = 1'b0;
        WriteMem = 1'b0;
        IRload   = 1'b0;
        halted   = 1'b0;
        case (r_state)
            ST_RST: begin
                ResetPC  = 1'b1;
                EnablePC = 1'b1;
            end
            ST_FETCH: begin
                ReadMem = 1'b1;
                IRload  = memDataReady;
            end
            ST_DISPATCH: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    case (op_kind)
                        OP_BR_REL: begin
                            PCplusI  = 1'b1;
                            EnablePC = 1'b1;
                        end
                        OP_JMP_REG: begin
                            RplusI   = 1'b1;
                            EnablePC = 1'b1;
                        end
                        OP_LOAD, OP_STORE, OP_HALT: begin
                        end
                        // NEXT and illegal kinds both advance the PC by one.
                        default: begin
                            PCplus1  = 1'b1;
                            EnablePC = 1'b1;
                        end
                    endcase
                end
            end
            ST_DRD: begin
                Rplus0  = 1'b1;
                ReadMem = 1'b1;
            end
            ST_DWR: begin
                Rplus0   = 1'b1;
                WriteMem = 1'b1;
            end
            ST_INCR: begin
                PCplus1  = 1'b1;
                EnablePC = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            default: begin
            end
        endcase
    end

endmodule
